mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single SDRAM/flash `mem_bus` target between NUM_PORTS controllers: N64 PI, USB/DMA, SD, etc.
- Single-outstanding-transaction arbiter with round-robin fairness.
- Registers the winning request's command and payload onto the downstream bus.
- Routes the ack and read data back to the granted port only.
- Sits between the controllers and the memory controller at the top level.

Parameters:
- NUM_PORTS, 3, number of requesting controllers (2..8); port 0 is the N64 PI.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 16, data word width; wmask width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_request  in  NUM_PORTS  per-port request; held high until that port's ack.
- req_write  in  NUM_PORTS  per-port write (1) / read (0).
- req_address  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- req_wmask  in  NUM_PORTS*DATA_WIDTH/8  per-port byte mask.
- req_ack  out  NUM_PORTS  one-cycle ack to the granted port.
- req_rdata  out  DATA_WIDTH  read data, shared by all ports; valid only with req_ack.
- mem_request  out  1  downstream request.
- mem_write  out  1  downstream direction.
- mem_address  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  DATA_WIDTH  downstream write data.
- mem_wmask  out  DATA_WIDTH/8  downstream byte mask.
- mem_ack  in  1  one-cycle completion from the memory controller.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- grant_id  out  3  index of the port currently owning the bus.
- busy  out  1  a transaction is outstanding.

Behaviour:
- Reset values:
  - state IDLE.
  - mem_request=0, mem_write=0, mem_address=0, mem_wdata=0, mem_wmask=0.
  - req_ack=0, grant_id=0, busy=0.
  - Round-robin pointer last_grant=NUM_PORTS-1, so port 0 wins first.
- States:
  - IDLE: if any req_request bit is set, select a winner and go to ACTIVE.
    - Winner is the first set bit searching upward from last_grant+1, modulo NUM_PORTS.
    - Register that port's write/address/wdata/wmask onto mem_*.
    - Set mem_request=1, busy=1, grant_id=winner, last_grant=winner.
  - ACTIVE: hold all mem_* outputs stable.
    - On mem_ack: req_ack[grant_id]=mem_ack combinationally in the same cycle.
    - req_rdata = mem_rdata, passed through unregistered in all states.
    - Register mem_request=0 and busy=0, then return to IDLE.
- Latency:
  - Request high at cycle t in IDLE → mem_request high at t+1.
  - mem_ack at cycle a → req_ack in cycle a.
  - Earliest next grant is sampled at a+1, so mem_request is high again at a+2.
- Back-to-back ordering: requesters clear req_request on the clock edge after ack, so the just-served port is not re-granted spuriously at a+1.
- Simultaneous requests: all ports requesting continuously are served strictly in rotation 0,1,2,0,…
- Payload sampling: payload is sampled only at the grant edge; later changes on the req_* inputs are ignored until the next grant.
- Protocol violation, request dropped while ACTIVE: the issued transaction completes and the ack is still pulsed to that port.
- mem_ack while IDLE: ignored, with req_ack all 0.
- req_ack is never asserted to a non-granted port, and at most one bit is set at a time.
- Reset mid-transaction: returns to IDLE immediately with mem_request=0. Any mem_ack arriving afterwards is ignored; the memory controller is reset by the same reset.

Optional Feature:
- Macro: MEM_BUS_ARBITER_PI_PRIORITY_EN.
- Defined:
  - Port 0 wins any IDLE arbitration in which it requests, regardless of last_grant.
  - Remaining ports rotate among themselves.
  - Round-robin pointer updates only on grants to ports 1..N-1.
  - Purpose: bounds N64 PI read latency.
- Undefined: pure round-robin over all ports, as above.

Test Plan:
- Single port 1 read, addr 0x0400_0010, memory acks 3 cycles after mem_request with rdata 0xBEEF → mem_address=0x0400_0010, mem_write=0, req_ack=3'b010 for one cycle, req_rdata=0xBEEF.
- Ports 0, 1 and 2 request continuously, 8 transactions with 1-cycle ack → grant order 0,1,2,0,1,2,0,1; mem_request re-asserts exactly 2 cycles after each ack.
- Port 2 write, wdata 0x1234, wmask 2'b11; port 2 changes req_wdata to 0xFFFF while ACTIVE → mem_wdata remains 0x1234 until ack.
- Reset asserted 1 cycle after grant; mem_ack pulses the cycle after reset deasserts → mem_request=0, busy=0, req_ack=0, and next grant goes to port 0.
- With MEM_BUS_ARBITER_PI_PRIORITY_EN: ports 0 and 1 request continuously → port 0 wins every grant. Port 0 idle, ports 1 and 2 requesting → grants alternate 1,2.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding round-robin arbiter sharing one mem_bus target between NUM_PORTS controllers.
// Define MEM_BUS_ARBITER_PI_PRIORITY_EN to give port 0 (N64 PI) absolute priority in arbitration.
module mem_bus_arbiter #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                req_request,
  input  logic [NUM_PORTS-1:0]                req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_wmask,
  output logic [NUM_PORTS-1:0]                req_ack,
  output logic [DATA_WIDTH-1:0]               req_rdata,
  output logic                                mem_request,
  output logic                                mem_write,
  output logic [ADDR_WIDTH-1:0]               mem_address,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  output logic [DATA_WIDTH/8-1:0]             mem_wmask,
  input  logic                                mem_ack,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic [2:0]                          grant_id,
  output logic                                busy
);

  localparam int unsigned MASK_W = DATA_WIDTH / 8;
  localparam int unsigned GID_W  = 3;

`ifdef MEM_BUS_ARBITER_PI_PRIORITY_EN
  localparam bit PI_PRIORITY = 1'b1;
  localparam int FIRST_RR    = 1;
`else
  localparam bit PI_PRIORITY = 1'b0;
  localparam int FIRST_RR    = 0;
`endif

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e              state_q;
  logic [GID_W-1:0]    last_grant_q;
  logic [GID_W-1:0]    grant_id_q;
  logic                mem_request_q;
  logic                mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;
  logic                busy_q;

  logic                win_valid;
  logic [GID_W-1:0]    win_idx;
  int                  idx;
  logic                sel_write;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MASK_W-1:0]   sel_wmask;

  // Rotating search from last_grant+1; smallest offset wins, port 0 may pre-empt the rotation.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = int'(NUM_PORTS); k > 0; k--) begin
      idx = (int'(last_grant_q) + k) % int'(NUM_PORTS);
      for (int i = FIRST_RR; i < int'(NUM_PORTS); i++) begin
        if (i == idx && req_request[i]) begin
          win_valid = 1'b1;
          win_idx   = GID_W'(i);
        end
      end
    end
    if (PI_PRIORITY && req_request[0]) begin
      win_valid = 1'b1;
      win_idx   = '0;
    end
  end

  // Payload of the winning port
  always_comb begin
    sel_write   = 1'b0;
    sel_address = '0;
    sel_wdata   = '0;
    sel_wmask   = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (GID_W'(i) == win_idx) begin
        sel_write   = req_write[i];
        sel_address = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wmask   = req_wmask[i*MASK_W +: MASK_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= GID_W'(NUM_PORTS - 1);
      grant_id_q    <= '0;
      mem_request_q <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q       <= ACTIVE;
            grant_id_q    <= win_idx;
            mem_request_q <= 1'b1;
            busy_q        <= 1'b1;
            mem_write_q   <= sel_write;
            mem_address_q <= sel_address;
            mem_wdata_q   <= sel_wdata;
            mem_wmask_q   <= sel_wmask;
            // With PI priority the pointer only tracks the rotating ports
            if (int'(win_idx) >= FIRST_RR) last_grant_q <= win_idx;
          end
        end
        ACTIVE: begin
          if (mem_ack) begin
            state_q       <= IDLE;
            mem_request_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
      endcase
    end
  end

  // Ack is routed back in the same cycle, only while a transaction is outstanding
  always_comb begin
    req_ack = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      req_ack[i] = (state_q == ACTIVE) && mem_ack && (grant_id_q == GID_W'(i));
    end
  end

  assign req_rdata   = mem_rdata;
  assign mem_request = mem_request_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requester and memory models, grant/ack monitor.
// Expected grant orders follow MEM_BUS_ARBITER_PI_PRIORITY_EN when it is defined.
module tb_mem_bus_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int MW = DW / 8;

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic [15:0] rdata;
    logic        chk_rd;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [NP-1:0]    req_request;
  logic [NP-1:0]    req_write;
  logic [NP*AW-1:0] req_address;
  logic [NP*DW-1:0] req_wdata;
  logic [NP*MW-1:0] req_wmask;
  logic [NP-1:0]    req_ack;
  logic [DW-1:0]    req_rdata;
  logic             mem_request;
  logic             mem_write;
  logic [AW-1:0]    mem_address;
  logic [DW-1:0]    mem_wdata;
  logic [MW-1:0]    mem_wmask;
  logic             mem_ack;
  logic [DW-1:0]    mem_rdata;
  logic [2:0]       grant_id;
  logic             busy;

  mem_bus_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_request(req_request), .req_write(req_write), .req_address(req_address),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ack(req_ack), .req_rdata(req_rdata),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        p_wr[NP];
  logic [31:0] p_addr[NP];
  logic [15:0] p_wdata[NP];
  logic [1:0]  p_wmask[NP];
  int          issue[NP];
  int          acked[NP];
  exp_t        sb[$];

  int          ack_delay = 0;
  logic        rd_force_en = 1'b0;
  logic [15:0] rd_force = '0;
  int          inject_cyc = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      req_write[i]            = p_wr[i];
      req_address[i*AW +: AW] = p_addr[i];
      req_wdata[i*DW +: DW]   = p_wdata[i];
      req_wmask[i*MW +: MW]   = p_wmask[i];
    end
  end

  // Requesters: hold request while issued transactions are un-acked
  initial begin
    req_request = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) req_request[i] = (issue[i] > acked[i]);
    end
  end

  // Memory model: acks ack_delay cycles after mem_request is seen; optional stray ack
  initial begin : mem_model
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (cyc == inject_cyc) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
      end else if (mem_request && !reset) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_force_en ? rd_force : (mem_address[15:0] ^ 16'h5A5A);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compare each grant and each ack against the scoreboard head
  exp_t cur;
  logic in_txn = 1'b0, req_prev = 1'b0, ack_prev = 1'b0, gap_exp = 1'b0;
  int   last_ack_cyc = 0;
  always @(negedge clk) begin
    logic [2:0] oh;
    int rem;
    if (reset) begin
      if (in_txn) void'(sb.pop_front());
      in_txn   = 1'b0;
      gap_exp  = 1'b0;
      ack_prev = 1'b0;
    end else begin
      if (ack_prev) check("ack_width", 64'(req_ack), 64'(0));
      if (mem_request && !req_prev) begin
        if (sb.size() == 0) begin
          check("grant_unexp", 64'(sb.size()), 64'(1));
        end else begin
          cur    = sb[0];
          in_txn = 1'b1;
          check("gnt_id", 64'(grant_id), 64'(cur.port));
          check("gnt_write", 64'(mem_write), 64'(cur.wr));
          check("gnt_addr", 64'(mem_address), 64'(cur.addr));
          check("gnt_wdata", 64'(mem_wdata), 64'(cur.wdata));
          check("gnt_wmask", 64'(mem_wmask), 64'(cur.wmask));
          check("gnt_busy", 64'(busy), 64'(1));
          if (gap_exp) check("regrant_gap", 64'(cyc - last_ack_cyc), 64'(2));
          gap_exp = 1'b0;
        end
      end
      if (mem_ack && !in_txn) check("ack_idle", 64'(req_ack), 64'(0));
      if (mem_ack && in_txn) begin
        oh = '0;
        oh[cur.port] = 1'b1;
        check("ack_port", 64'(req_ack), 64'(oh));
        if (cur.chk_rd) check("ack_rdata", 64'(req_rdata), 64'(cur.rdata));
        check("hold_addr", 64'(mem_address), 64'(cur.addr));
        check("hold_wdata", 64'(mem_wdata), 64'(cur.wdata));
        void'(sb.pop_front());
        in_txn = 1'b0;
        acked[cur.port]++;
        rem = 0;
        for (int i = 0; i < NP; i++) if (issue[i] > acked[i]) rem += issue[i] - acked[i];
        gap_exp      = (rem > 0);
        last_ack_cyc = cyc;
      end else if (!mem_ack && req_ack != '0) begin
        check("ack_spur", 64'(req_ack), 64'(0));
      end
      ack_prev = (req_ack != '0);
    end
    req_prev = mem_request;
  end

  task automatic push(input int p);
    exp_t e;
    e.port   = p;
    e.wr     = p_wr[p];
    e.addr   = p_addr[p];
    e.wdata  = p_wdata[p];
    e.wmask  = p_wmask[p];
    e.chk_rd = !p_wr[p];
    e.rdata  = rd_force_en ? rd_force : (p_addr[p][15:0] ^ 16'h5A5A);
    sb.push_back(e);
  endtask

  task automatic add_req(input int p, input int n);
    issue[p] = acked[p] + n;
  endtask

  task automatic wait_done(input int budget);
    int b = 0;
    while (sb.size() != 0 && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() != 0) check("done_timeout", 64'(sb.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_grant(input int budget);
    int b = 0;
    while (!mem_request && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (!mem_request) check("grant_timeout", 64'(mem_request), 64'(1));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < NP; i++) issue[i] = acked[i];
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_mreq"}, 64'(mem_request), 64'(0));
    check({tag, "_mwr"}, 64'(mem_write), 64'(0));
    check({tag, "_maddr"}, 64'(mem_address), 64'(0));
    check({tag, "_mwdata"}, 64'(mem_wdata), 64'(0));
    check({tag, "_mwmask"}, 64'(mem_wmask), 64'(0));
    check({tag, "_ack"}, 64'(req_ack), 64'(0));
    check({tag, "_gid"}, 64'(grant_id), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin : main
    int ord[8];
    int ord_a[5];
    int ord_b[4];
    reset = 1'b1;
    for (int i = 0; i < NP; i++) begin
      p_wr[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; p_wmask[i] = '0;
      issue[i] = 0; acked[i] = 0;
    end
    do_reset("rst0");

    // Single read from port 1 with a 3-cycle memory latency
    p_addr[1] = 32'h0400_0010; p_wr[1] = 1'b0; p_wdata[1] = 16'h0001; p_wmask[1] = 2'b01;
    ack_delay = 3; rd_force_en = 1'b1; rd_force = 16'hBEEF;
    push(1);
    @(negedge clk);
    add_req(1, 1);
    @(negedge clk);
    check("t1_pre", 64'(mem_request), 64'(0));
    @(negedge clk);
    check("t1_lat", 64'(mem_request), 64'(1));
    check("t1_addr", 64'(mem_address), 64'(32'h0400_0010));
    check("t1_write", 64'(mem_write), 64'(0));
    @(negedge clk);
    @(negedge clk);
    check("t1_noack", 64'(req_ack), 64'(0));
    @(negedge clk);
    check("t1_ack", 64'(req_ack), 64'(3'b010));
    check("t1_rdata", 64'(req_rdata), 64'(16'hBEEF));
    @(negedge clk);
    check("t1_ack_off", 64'(req_ack), 64'(0));
    check("t1_busy", 64'(busy), 64'(0));
    wait_done(20);
    rd_force_en = 1'b0;

    // All three ports requesting with single-cycle acks
    do_reset("rst1");
    for (int i = 0; i < NP; i++) begin
      p_wr[i] = 1'b0; p_addr[i] = 32'h1000_0000 + 32'(i) * 32'h104;
      p_wdata[i] = 16'h0A00 + 16'(i); p_wmask[i] = 2'b10;
    end
    ack_delay = 0;
`ifdef MEM_BUS_ARBITER_PI_PRIORITY_EN
    ord = '{0, 0, 0, 1, 2, 1, 2, 1};
`else
    ord = '{0, 1, 2, 0, 1, 2, 0, 1};
`endif
    for (int k = 0; k < 8; k++) push(ord[k]);
    @(negedge clk);
    add_req(0, 3); add_req(1, 3); add_req(2, 2);
    wait_done(200);

    // Port 2 write; its payload changes after the grant and must not reach the bus
    p_wr[2] = 1'b1; p_addr[2] = 32'h0000_0200; p_wdata[2] = 16'h1234; p_wmask[2] = 2'b11;
    ack_delay = 4;
    push(2);
    add_req(2, 1);
    wait_grant(20);
    p_wdata[2] = 16'hFFFF;
    p_addr[2]  = 32'h0000_0AAA;
    @(negedge clk);
    check("t3_hold_wdata", 64'(mem_wdata), 64'(16'h1234));
    check("t3_hold_wr", 64'(mem_write), 64'(1));
    wait_done(40);
    p_wr[2] = 1'b0; p_wdata[2] = 16'h0A02; p_addr[2] = 32'h1000_0208;

    // Port 0 drops its request while ACTIVE; ack still goes to port 0
    p_addr[0] = 32'h0000_0300;
    ack_delay = 2;
    push(0);
    add_req(0, 1);
    wait_grant(20);
    issue[0] = acked[0];
    wait_done(40);

    // Port 0 heavy plus port 1, then ports 1 and 2 sharing
    ack_delay = 1;
`ifdef MEM_BUS_ARBITER_PI_PRIORITY_EN
    ord_a = '{0, 0, 0, 0, 1};
    ord_b = '{2, 1, 2, 1};
`else
    ord_a = '{1, 0, 0, 0, 0};
    ord_b = '{1, 2, 1, 2};
`endif
    for (int k = 0; k < 5; k++) push(ord_a[k]);
    add_req(0, 4); add_req(1, 1);
    wait_done(200);
    for (int k = 0; k < 4; k++) push(ord_b[k]);
    add_req(1, 2); add_req(2, 2);
    wait_done(200);

    // Reset one cycle after a grant, then a stray mem_ack while IDLE
    ack_delay = 10;
    push(1);
    add_req(1, 1);
    wait_grant(20);
    @(posedge clk); #1;
    reset = 1'b1;
    issue[1] = acked[1];
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_mreq", 64'(mem_request), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_ack", 64'(req_ack), 64'(0));
    inject_cyc = cyc + 1;
    @(negedge clk);
    check("rst_mid_stray_seen", 64'(mem_ack), 64'(1));
    check("rst_mid_stray_ack", 64'(req_ack), 64'(0));
    check("rst_mid_stray_busy", 64'(busy), 64'(0));
    ack_delay = 1;
    push(0); push(1);
    add_req(0, 1); add_req(1, 1);
    wait_done(60);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
